// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolve path: default widths and the
// redundant (sum, carry) pair type produced by the 4:2 CSA array.
package csa_pkg;

    localparam int CSA_W    = 25;
    localparam int CSA_LO_W = 13;

    typedef struct packed {
        logic [CSA_W-1:0] sum;
        logic [CSA_W-1:0] carry;
    } csa_pair_t;

endpackage

// File: rtl/csa_resolve_half.sv
// N-bit unsigned adder with carry-in and a full N+1-bit result; one instance
// per pipeline stage of the carry-save resolver.
module csa_resolve_half #(
    parameter int N = 13
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N:0]   s
);

    assign s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve_pipe.sv
// Two-stage resolver of a carry-save pair into a binary sum with valid/ready
// handshake and tag sideband. Define CSA_RESOLVE_ZERO_FLAG_EN to add out_zero.
module csa_resolve_pipe
    import csa_pkg::*;
#(
    parameter int IN_W  = CSA_W,
    parameter int LO_W  = CSA_LO_W,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    input  logic [IN_W-1:0]  in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IN_W:0]    out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);

    localparam int HI_W = IN_W - LO_W;

    logic             s1_valid;
    logic [LO_W:0]    s1_lo;
    logic [HI_W-1:0]  s1_sum_hi;
    logic [HI_W-1:0]  s1_carry_hi;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [IN_W:0]    s2_result;
    logic [TAG_W-1:0] s2_tag;

    logic             accept;
    logic             s2_adv;
    logic [LO_W:0]    lo_sum;
    logic [HI_W:0]    hi_sum;

    assign s2_adv   = s1_valid && (!s2_valid || out_ready);
    // Reset gates in_ready so nothing looks accepted while the pipe is held.
    assign in_ready = reset && !flush && (!s1_valid || s2_adv);
    assign accept   = in_valid && in_ready;

    csa_resolve_half #(.N(LO_W)) u_lo (
        .a   (in_sum[LO_W-1:0]),
        .b   (in_carry[LO_W-1:0]),
        .cin (1'b0),
        .s   (lo_sum)
    );

    csa_resolve_half #(.N(HI_W)) u_hi (
        .a   (s1_sum_hi),
        .b   (s1_carry_hi),
        .cin (s1_lo[LO_W]),
        .s   (hi_sum)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid    <= 1'b0;
            s1_lo       <= '0;
            s1_sum_hi   <= '0;
            s1_carry_hi <= '0;
            s1_tag      <= '0;
            s2_valid    <= 1'b0;
            s2_result   <= '0;
            s2_tag      <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                s1_valid <= accept ? 1'b1 : (s2_adv ? 1'b0 : s1_valid);
                s2_valid <= s2_adv ? 1'b1 : (out_ready ? 1'b0 : s2_valid);
            end
            if (accept) begin
                s1_lo       <= lo_sum;
                s1_sum_hi   <= in_sum[IN_W-1:LO_W];
                s1_carry_hi <= in_carry[IN_W-1:LO_W];
                s1_tag      <= in_tag;
            end
            if (s2_adv && !flush) begin
                s2_result <= {hi_sum, s1_lo[LO_W-1:0]};
                s2_tag    <= s1_tag;
            end
        end
    end

`ifdef CSA_RESOLVE_ZERO_FLAG_EN
    logic s1_lo_zero;
    logic s2_zero;

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_lo_zero <= 1'b0;
            s2_zero    <= 1'b0;
        end else begin
            if (accept)
                s1_lo_zero <= (lo_sum == '0);
            if (s2_adv && !flush)
                s2_zero <= s1_lo_zero && (hi_sum == '0);
        end
    end

    assign out_zero = s2_zero;
`endif

    assign out_valid  = s2_valid && reset;
    assign out_result = s2_result;
    assign out_tag    = s2_tag;

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// Directed and scoreboard checks for the two-stage carry-save resolver.
module tb_csa_resolve_pipe;
    import csa_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_sum;
    logic [24:0] in_carry;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_result;
    logic [3:0]  out_tag;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
    logic        out_zero;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    csa_resolve_pipe dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
        ,
        .out_zero   (out_zero)
`endif
    );

    typedef struct {
        csa_pair_t   pair;
        logic [3:0]  tag;
        logic [25:0] exp;
    } vec_t;

    typedef struct {
        logic [25:0] res;
        logic [3:0]  tag;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int got;
        int cyc;
        logic [25:0] held_res;
        logic [3:0]  held_tag;
        logic        was_stalled;
        logic [25:0] pa;

        vecs[0] = '{'{25'h0001FFF, 25'h0000001}, 4'd3,  26'h0002000};
        vecs[1] = '{'{25'h1FFFFFF, 25'h1FFFFFF}, 4'd5,  26'h3FFFFFE};
        vecs[2] = '{'{25'h0000000, 25'h0000000}, 4'd0,  26'h0000000};
        vecs[3] = '{'{25'h0FFFFFF, 25'h0000001}, 4'd9,  26'h1000000};
        vecs[4] = '{'{25'h1000000, 25'h1000000}, 4'd15, 26'h2000000};
        vecs[5] = '{'{25'h0001000, 25'h0001000}, 4'd1,  26'h0002000};
        vecs[6] = '{'{25'h0123456, 25'h0654321}, 4'd7,  26'h0777777};

        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_sum = 25'd5; in_carry = 25'd6; in_tag = 4'd2;

        // Reset held with in_valid asserted.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_result", {6'd0, out_result}, 32'd0);
            chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        end
        reset = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("rel_not_yet", {31'd0, out_valid}, 32'd0);
        step();
        chk("rel_valid", {31'd0, out_valid}, 32'd1);
        chk("rel_result", {6'd0, out_result}, 32'd11);
        chk("rel_tag", {28'd0, out_tag}, 32'd2);
        step();

        // Single-shot vectors, 2-cycle latency, consumer always ready.
        for (int v = 0; v < 7; v++) begin
            in_valid = 1'b1;
            in_sum   = vecs[v].pair.sum;
            in_carry = vecs[v].pair.carry;
            in_tag   = vecs[v].tag;
            step();
            in_valid = 1'b0;
            step();
            chk("vec_valid", {31'd0, out_valid}, 32'd1);
            chk("vec_result", {6'd0, out_result}, {6'd0, vecs[v].exp});
            chk("vec_tag", {28'd0, out_tag}, {28'd0, vecs[v].tag});
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
            chk("vec_zero", {31'd0, out_zero}, {31'd0, vecs[v].exp == 26'd0});
`endif
        end
        step();
        chk("drained", {31'd0, out_valid}, 32'd0);

        // Backpressure stream: pairs (i, 2i) with a stuttering consumer.
        got = 0; was_stalled = 1'b0; held_res = '0; held_tag = '0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_sum = 25'(i); in_carry = 25'(2 * i); in_tag = 4'(i);
            cyc = 0;
            do begin
                out_ready = (cyc % 3 == 0);
                #1;
                if (was_stalled) begin
                    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                    chk("bp_hold_result", {6'd0, out_result}, {6'd0, held_res});
                    chk("bp_hold_tag", {28'd0, out_tag}, {28'd0, held_tag});
                end
                if (out_valid && out_ready) begin
                    got++;
                    chk("bp_result", {6'd0, out_result}, 32'(3 * got));
                    chk("bp_tag", {28'd0, out_tag}, 32'(got));
                end
                was_stalled = out_valid && !out_ready;
                held_res = out_result; held_tag = out_tag;
                pa = {25'd0, in_ready};
                cyc++;
                @(posedge clock); #1;
            end while (pa[0] == 1'b0 && cyc < 50);
            if (cyc >= 50) chk("bp_accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        cyc = 0;
        while (got < 8 && cyc < 50) begin
            out_ready = (cyc % 3 == 0);
            #1;
            if (was_stalled)
                chk("bp_hold_result", {6'd0, out_result}, {6'd0, held_res});
            if (out_valid && out_ready) begin
                got++;
                chk("bp_result", {6'd0, out_result}, 32'(3 * got));
                chk("bp_tag", {28'd0, out_tag}, 32'(got));
            end
            was_stalled = out_valid && !out_ready;
            held_res = out_result;
            cyc++;
            @(posedge clock); #1;
        end
        chk("bp_count", 32'(got), 32'd8);
        out_ready = 1'b1;
        step();

        // Full-throughput stream with consumer always ready.
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4); in_sum = 25'(100 + i); in_carry = 25'd1; in_tag = 4'(i);
            #1;
            if (i < 4) chk("ft_in_ready", {31'd0, in_ready}, 32'd1);
            if (i >= 2) begin
                chk("ft_valid", {31'd0, out_valid}, 32'd1);
                chk("ft_result", {6'd0, out_result}, 32'(101 + i - 2));
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;

        // Flush with two entries in flight and a pop in the same cycle.
        out_ready = 1'b0;
        in_valid = 1'b1; in_sum = 25'd10; in_carry = 25'd20; in_tag = 4'd4;
        step();
        in_sum = 25'd40; in_carry = 25'd50; in_tag = 4'd6;
        step();
        in_sum = 25'd70; in_carry = 25'd80; in_tag = 4'd8;
        #1;
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1; flush = 1'b1;
        #1;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fl_valid", {31'd0, out_valid}, 32'd1);
        chk("fl_result", {6'd0, out_result}, 32'd30);
        chk("fl_tag", {28'd0, out_tag}, 32'd4);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_empty", {31'd0, out_valid}, 32'd0);
        chk("fl_ready_after", {31'd0, in_ready}, 32'd1);
        step();
        chk("fl_s1_dropped", {31'd0, out_valid}, 32'd0);

        // Random traffic against a queue scoreboard; flush drops the rest.
        got = 0;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sum    = 25'($urandom);
            in_carry  = 25'($urandom);
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_unexpected_pop", 32'd1, 32'd0);
                end else begin
                    chk("rnd_result", {6'd0, out_result}, {6'd0, sb[0].res});
                    chk("rnd_tag", {28'd0, out_tag}, {28'd0, sb[0].tag});
                    void'(sb.pop_front());
                    got++;
                end
            end
            if (flush) begin
                if (in_ready) chk("rnd_flush_ready", 32'd1, 32'd0);
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back('{26'(in_sum) + 26'(in_carry), in_tag});
            end
            @(posedge clock); #1;
        end
        if (got < 500) chk("rnd_pops", 32'(got), 32'd500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
